tx_arb_ser: RTL and testbench
=============================

TX_ARB_SER -- requirements
Module: tx_arb_ser

Interface
REQ-001 Parameter NCH, default 4, meaning number of request channels (legal 1..8).
REQ-002 Parameter WBYTES, default 2, meaning payload bytes per word (legal 1..4).
REQ-003 Port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port req  input  NCH  per-channel request to send, active high, level-held until accepted.
REQ-006 Port din  input  NCH*8*WBYTES  channel k word at bits [k*8*WBYTES +: 8*WBYTES].
REQ-007 Port wfull  input  1  downstream tx FIFO full, active high.
REQ-008 Port out  output  8  byte to FIFO, valid when winc high.
REQ-009 Port winc  output  1  FIFO write strobe, active high, one byte per high cycle.
REQ-010 Port accept  output  NCH  one-hot "word sent" acknowledge to the granted channel.

Function
REQ-011 States SHALL be IDLE, HDR, DATA, CKS (macro only), ACK, FIN.
REQ-012 IDLE with any req bit high SHALL grant one channel by round-robin, register its index (sel) and snapshot its din word, and go to HDR next cycle.
REQ-013 Round-robin: search starts at channel ptr, ascending with wrap; after each grant ptr = (sel+1) mod NCH.
REQ-014 HDR SHALL drive out = sel+1; winc = !wfull; on a write go to DATA with byte counter = WBYTES-1.
REQ-015 DATA SHALL drive out = snapshot byte [counter] (MSB first); winc = !wfull; on a write decrement counter; write at counter 0 goes to CKS if compiled in, else ACK.
REQ-016 winc SHALL be combinational on state and wfull: never high while wfull high, never high in IDLE/ACK/FIN.
REQ-017 While wfull high the FSM SHALL hold its state, counter and out value unchanged.
REQ-018 ACK SHALL drive accept[sel]=1, others 0; leave to FIN when req[sel]==0, otherwise hold indefinitely.
REQ-019 FIN SHALL drive all outputs 0 and return to IDLE after one cycle; req changes during FIN ignored.
REQ-020 Snapshot SHALL be immune to din changes after grant; req changes of non-granted channels SHALL not affect an ongoing transfer.
REQ-021 Minimum cycles per word with wfull low: 1 (IDLE) + 1 + WBYTES (+1 CKS) writes + ACK cycles + 1 FIN.
REQ-022 out SHALL be 0 in IDLE, ACK and FIN.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, ptr 0, sel 0, counter 0, snapshot 0, checksum 0; out, winc, accept all 0.
REQ-024 Reset mid-transfer SHALL abandon the word; no partial accept is issued; after release the channel re-requests normally.

Configuration
REQ-025 Macro TX_ARB_SER_CKSUM_EN defined: after the last data byte, state CKS SHALL write one byte = XOR of header byte and all payload bytes, same wfull rules as DATA.
REQ-026 Macro undefined: no CKS state, no checksum register; frame is header + WBYTES bytes.

Structure
REQ-027 Shared package tx_pkg SHALL hold the state encoding constants and the header-offset constant (1).
REQ-028 Sub-module rr_arb (NCH-wide round-robin grant from req and ptr, combinational) SHALL be instantiated once.

Verification
REQ-029 NCH=4, WBYTES=2, req=0001, din ch0=16'hA55A, wfull=0 -> winc bytes 01, A5, 5A in consecutive cycles, then accept=0001 until req[0] drops.
REQ-030 req=1111 held and re-asserted after each accept -> headers in order 01,02,03,04,01 (round-robin rotation).
REQ-031 wfull high for 3 cycles during DATA at first payload byte -> winc low those 3 cycles, out stable, byte sequence unchanged.
REQ-032 din ch2 changes from 16'h1234 to 16'hFFFF one cycle after grant -> bytes 03,12,34 still sent.
REQ-033 rst_n low in DATA -> outputs 0 at once; after release with req=0100 a fresh frame 03,... is sent.
REQ-034 TX_ARB_SER_CKSUM_EN, ch1 word 16'h0F0F -> bytes 02,0F,0F,02 (XOR checksum).

Source files
------------

// File: rtl/tx_arb_ser_pkg.sv
// Shared types for the tx_arb_ser slice: FSM state encoding and header offset.
// TX_ARB_SER_CKSUM_EN adds the CKS state used for the trailing XOR byte.
package tx_pkg;

  localparam logic [7:0] HDR_OFS = 8'd1;
  localparam int         CW      = 2;

`ifdef TX_ARB_SER_CKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_CKS,
    S_ACK,
    S_FIN
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_ACK,
    S_FIN
  } state_t;
`endif

endpackage

// File: rtl/tx_arb_ser_rr_arb.sv
// Combinational round-robin arbiter: first set req at or after ptr, wrapping.
// Ports: req_i requests, ptr_i search start, vld_o any grant, gnt_o index.
module rr_arb
  import tx_pkg::*;
#(
  parameter  int NCH = 4,
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] req_i,
  input  logic [IW-1:0]  ptr_i,
  output logic           vld_o,
  output logic [IW-1:0]  gnt_o
);

  logic [NCH-1:0] rot;
  int             s;

  // rot[i] is the request of channel (ptr+i) mod NCH
  always_comb begin
    rot   = NCH'({req_i, req_i} >> ptr_i);
    vld_o = 1'b0;
    gnt_o = '0;
    s     = 0;
    // descending so the smallest offset wins
    for (int i = NCH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        s = int'(ptr_i) + i;
        if (s >= NCH) s = s - NCH;
        vld_o = 1'b1;
        gnt_o = IW'(s);
      end
    end
  end

endmodule

// File: rtl/tx_arb_ser.sv
// Round-robin word arbiter and byte serializer: header, payload MSB first.
// Ports: req/din/wfull in; out/winc/accept out. Option TX_ARB_SER_CKSUM_EN.
module tx_arb_ser
  import tx_pkg::*;
#(
  parameter  int NCH    = 4,
  parameter  int WBYTES = 2,
  localparam int IW     = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int DW     = 8 * WBYTES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    req,
  input  logic [NCH*DW-1:0] din,
  input  logic              wfull,
  output logic [7:0]        out,
  output logic              winc,
  output logic [NCH-1:0]    accept
);

  state_t         state_q;
  logic [IW-1:0]  sel_q;
  logic [IW-1:0]  ptr_q;
  logic [CW-1:0]  cnt_q;
  logic [DW-1:0]  snap_q;
`ifdef TX_ARB_SER_CKSUM_EN
  logic [7:0]     cks_q;
`endif

  logic           gvld;
  logic [IW-1:0]  gidx;
  logic [DW-1:0]  gword;
  logic [7:0]     hdr;
  logic [7:0]     dbyte;

  rr_arb #(
    .NCH (NCH)
  ) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .vld_o (gvld),
    .gnt_o (gidx)
  );

  assign gword = DW'(din >> (int'(gidx) * DW));
  assign hdr   = 8'(sel_q) + HDR_OFS;
  assign dbyte = 8'(snap_q >> {cnt_q, 3'b000});

  always_comb begin
    out    = '0;
    winc   = 1'b0;
    accept = '0;
    unique case (state_q)
      S_HDR: begin
        out  = hdr;
        winc = !wfull;
      end
      S_DATA: begin
        out  = dbyte;
        winc = !wfull;
      end
`ifdef TX_ARB_SER_CKSUM_EN
      S_CKS: begin
        out  = cks_q;
        winc = !wfull;
      end
`endif
      S_ACK:   accept = NCH'(1) << sel_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      snap_q  <= '0;
`ifdef TX_ARB_SER_CKSUM_EN
      cks_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (gvld) begin
            sel_q   <= gidx;
            snap_q  <= gword;
            ptr_q   <= (gidx == IW'(NCH - 1)) ? '0 : gidx + 1'b1;
            state_q <= S_HDR;
          end
        end
        S_HDR: begin
          if (!wfull) begin
            cnt_q   <= CW'(WBYTES - 1);
`ifdef TX_ARB_SER_CKSUM_EN
            cks_q   <= hdr;
`endif
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (!wfull) begin
`ifdef TX_ARB_SER_CKSUM_EN
            cks_q <= cks_q ^ dbyte;
`endif
            if (cnt_q == '0) begin
`ifdef TX_ARB_SER_CKSUM_EN
              state_q <= S_CKS;
`else
              state_q <= S_ACK;
`endif
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
`ifdef TX_ARB_SER_CKSUM_EN
        S_CKS: begin
          if (!wfull) state_q <= S_ACK;
        end
`endif
        // accept is one-hot on sel, so this tests req[sel]
        S_ACK: begin
          if (~|(req & accept)) state_q <= S_FIN;
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_arb_ser.sv
// Self-checking bench for tx_arb_ser: vector table, corner sequences, random.
// Follows TX_ARB_SER_CKSUM_EN for the expected frame length.
module tb_tx_arb_ser;

  localparam int NCH = 4;
  localparam int WB  = 2;
  localparam int DW  = 8 * WB;
`ifdef TX_ARB_SER_CKSUM_EN
  localparam int FL  = WB + 2;
`else
  localparam int FL  = WB + 1;
`endif

  typedef logic [7:0] bq_t[$];

  typedef struct {
    int            ch;
    logic [DW-1:0] w;
    logic [7:0]    hdr;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    req;
  logic [NCH*DW-1:0] din;
  logic              wfull;
  logic [7:0]        out;
  logic              winc;
  logic [NCH-1:0]    accept;

  tx_arb_ser #(
    .NCH    (NCH),
    .WBYTES (WB)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .din    (din),
    .wfull  (wfull),
    .out    (out),
    .winc   (winc),
    .accept (accept)
  );

  always #5 clk = ~clk;

  int             checks = 0;
  int             errors = 0;
  int             cyc    = 0;
  int             acc_cyc;
  int             mptr;
  bq_t            got;
  int             stamp[$];
  logic [NCH-1:0] accq[$];
  logic [7:0]     s_out;
  logic           s_winc;
  logic [NCH-1:0] s_acc;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // sample what the coming edge commits, then advance one cycle
  task automatic cycle();
    #1;
    if (winc) begin
      chk("winc_while_full", 32'(wfull), 0);
      got.push_back(out);
      stamp.push_back(cyc);
    end
    s_out  = out;
    s_winc = winc;
    s_acc  = accept;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_word(int ch, logic [DW-1:0] w);
    logic [NCH*DW-1:0] m;
    m   = (NCH*DW)'({DW{1'b1}}) << (ch * DW);
    din = (din & ~m) | ((NCH*DW)'(w) << (ch * DW));
  endtask

  function automatic bq_t mk_frame(int ch, logic [DW-1:0] w);
    bq_t        q;
    logic [7:0] x;
    logic [7:0] b;
    x = 8'(ch + 1);
    q.push_back(x);
    for (int i = WB - 1; i >= 0; i--) begin
      b = 8'(w >> (8 * i));
      q.push_back(b);
      x = x ^ b;
    end
`ifdef TX_ARB_SER_CKSUM_EN
    q.push_back(x);
`endif
    return q;
  endfunction

  task automatic cmpq(string name, bq_t exp);
    int n;
    chk({name, "_len"}, 32'(got.size()), 32'(exp.size()));
    n = (got.size() < exp.size()) ? got.size() : exp.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_b%0d", name, i), 32'(got[i]), 32'(exp[i]));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    wfull = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mptr  = 0;
  endtask

  // hold m, drop each bit on its accept; optional re-arm, random wfull,
  // and scrambling of a channel's din right after its header byte
  task automatic serve(input logic [NCH-1:0] m, input bit rearm,
                       input int nacc, input bit wrand, input bit scr);
    int             n;
    int             pos;
    logic [NCH-1:0] pend;
    n       = 0;
    pos     = 0;
    pend    = '0;
    acc_cyc = -1;
    req     = m;
    for (int t = 0; t < 400 && n < nacc; t++) begin
      wfull = wrand ? 1'($urandom_range(0, 1)) : 1'b0;
      cycle();
      if (s_winc) begin
        if (pos == 0 && scr) set_word(int'(s_out) - 1, DW'($urandom));
        pos = (pos + 1) % FL;
      end
      if (s_acc != '0 && (req & s_acc) != '0) begin
        if (acc_cyc < 0) acc_cyc = cyc - 1;
        accq.push_back(s_acc);
        req = req & ~s_acc;
        if (rearm) pend = pend | s_acc;
        n++;
      end else if (s_acc == '0 && pend != '0) begin
        req  = req | pend;
        pend = '0;
      end
    end
    if (n < nacc) chk("serve_timeout", 32'(n), 32'(nacc));
    req   = '0;
    wfull = 1'b0;
    repeat (3) cycle();
  endtask

  task automatic clr();
    got.delete();
    stamp.delete();
    accq.delete();
  endtask

  vec_t           tbl[6];
  bq_t            expq;
  int             order[$];
  logic [NCH-1:0] m;
  logic [DW-1:0]  wv[NCH];
  int             t;

  initial begin
    tbl[0] = '{0, 16'hA55A, 8'h01};
    tbl[1] = '{2, 16'h1234, 8'h03};
    tbl[2] = '{3, 16'h0000, 8'h04};
    tbl[3] = '{1, 16'hFFFF, 8'h02};
    tbl[4] = '{0, 16'h8001, 8'h01};
    tbl[5] = '{3, 16'h7E81, 8'h04};

    din   = '0;
    rst_n = 1'b0;
    req   = '1;
    wfull = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_out", 32'(out), 0);
    chk("rst_winc", 32'(winc), 0);
    chk("rst_accept", 32'(accept), 0);
    do_reset();

    foreach (tbl[i]) begin
      clr();
      set_word(tbl[i].ch, tbl[i].w);
      serve(NCH'(1) << tbl[i].ch, 1'b0, 1, 1'b0, 1'b0);
      if (got.size() > 0) chk("tbl_hdr", 32'(got[0]), 32'(tbl[i].hdr));
      cmpq($sformatf("tbl%0d", i), mk_frame(tbl[i].ch, tbl[i].w));
      if (accq.size() > 0)
        chk("tbl_accept", 32'(accq[0]), 32'(NCH'(1) << tbl[i].ch));
      if (stamp.size() == FL) begin
        chk("tbl_consec", 32'(stamp[FL-1] - stamp[0]), 32'(FL - 1));
        chk("tbl_acc_lat", 32'(acc_cyc - stamp[FL-1]), 1);
      end
    end

    // rotation with all channels held and re-armed
    do_reset();
    clr();
    for (int k = 0; k < NCH; k++) set_word(k, DW'(16'h1100 * (k + 1)));
    serve('1, 1'b1, 5, 1'b0, 1'b0);
    chk("rr_len", 32'(got.size()), 32'(5 * FL));
    for (int i = 0; i < 5; i++)
      if (got.size() > i * FL)
        chk($sformatf("rr_hdr%0d", i), 32'(got[i*FL]), 32'((i % NCH) + 1));

    // wfull stall on first payload byte
    clr();
    set_word(1, 16'hC33C);
    req = 4'b0010;
    t = 0;
    while (got.size() < 1 && t < 20) begin
      cycle();
      t++;
    end
    chk("stall_hdr_seen", 32'(got.size()), 1);
    wfull = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_winc", 32'(s_winc), 0);
      chk("stall_out", 32'(s_out), 32'h0C3);
    end
    serve(4'b0010, 1'b0, 1, 1'b0, 1'b0);
    cmpq("stall", mk_frame(1, 16'hC33C));

    // din change one cycle after grant
    clr();
    set_word(2, 16'h1234);
    req = 4'b0100;
    cycle();
    set_word(2, 16'hFFFF);
    serve(4'b0100, 1'b0, 1, 1'b0, 1'b0);
    cmpq("snap", mk_frame(2, 16'h1234));

    // reset while in DATA
    clr();
    set_word(2, 16'h5AA5);
    req = 4'b0100;
    t = 0;
    while (got.size() < 1 && t < 20) begin
      cycle();
      t++;
    end
    chk("mid_hdr_seen", 32'(got.size()), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out", 32'(out), 0);
    chk("mid_rst_winc", 32'(winc), 0);
    chk("mid_rst_acc", 32'(accept), 0);
    @(negedge clk);
    rst_n = 1'b1;
    clr();
    serve(4'b0100, 1'b0, 1, 1'b0, 1'b0);
    cmpq("mid", mk_frame(2, 16'h5AA5));
    if (accq.size() > 0) chk("mid_accept", 32'(accq[0]), 32'h4);

`ifdef TX_ARB_SER_CKSUM_EN
    clr();
    set_word(1, 16'h0F0F);
    serve(4'b0010, 1'b0, 1, 1'b0, 1'b0);
    if (got.size() == 4) chk("cks_byte", 32'(got[3]), 32'h02);
    else chk("cks_len", 32'(got.size()), 4);
`endif

    // random rounds against the round-robin model
    do_reset();
    for (int r = 0; r < 30; r++) begin
      clr();
      m = NCH'($urandom_range(1, (1 << NCH) - 1));
      for (int k = 0; k < NCH; k++) begin
        wv[k] = DW'($urandom);
        set_word(k, wv[k]);
      end
      order.delete();
      for (int i = 0; i < NCH; i++) begin
        int c;
        c = (mptr + i) % NCH;
        if (m[c]) order.push_back(c);
      end
      expq.delete();
      foreach (order[i]) expq = {expq, mk_frame(order[i], wv[order[i]])};
      mptr = (order[order.size()-1] + 1) % NCH;
      serve(m, 1'b0, order.size(), 1'b1, 1'b1);
      cmpq($sformatf("rnd%0d", r), expq);
      chk("rnd_nacc", 32'(accq.size()), 32'(order.size()));
      foreach (accq[i])
        if (i < order.size())
          chk("rnd_acc", 32'(accq[i]), 32'(NCH'(1) << order[i]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
